// File: rtl/clock_pkg.sv
// Shared types for the clock sequencer family: FSM state encoding and
// status counter widths.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs; clears to 0
// on an asynchronous active-low reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/clock_sequencer.sv
// Supervises the DCM: pulses its reset, waits for a settled lock, then
// releases the downstream system reset; retries on timeout/loss, faults when out of budget.
module clock_sequencer
    import clock_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int LOSS_FILTER   = 4,
    parameter int MAX_RETRY     = 7,
    parameter int CW            = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               locked,
    input  logic               clkin_stopped,
    input  logic               restart,
    output logic               dcm_rst,
    output logic               ready,
    output logic               sys_rst,
    output logic               fault,
    output logic [RETRY_W-1:0] retries,
    output logic [LOSS_W-1:0]  losses
);

    localparam logic [CW-1:0]      RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]      LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]      SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]      LOSS_LAST   = CW'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    logic lk;
    logic stp;
    logic lost;

    sync2 #(.WIDTH(1)) u_sync_locked (
        .clk   (clock),
        .rst_n (reset),
        .d     (locked),
        .q     (lk)
    );

    sync2 #(.WIDTH(1)) u_sync_stopped (
        .clk   (clock),
        .rst_n (reset),
        .d     (clkin_stopped),
        .q     (stp)
    );

    assign lost = !lk || stp;

    state_t             state_reg,   state_next;
    logic [CW-1:0]      cnt_reg,     cnt_next;
    logic [RETRY_W-1:0] retries_reg, retries_next;
    logic [LOSS_W-1:0]  losses_reg,  losses_next;
    logic               dcm_rst_reg, ready_reg, sys_rst_reg, fault_reg;
    logic               dcm_rst_next, ready_next, fault_next;
    logic [RETRY_W-1:0] retry_inc;
    logic [LOSS_W-1:0]  loss_inc;

    assign retry_inc = (retries_reg == '1) ? retries_reg : retries_reg + RETRY_W'(1);
    assign loss_inc  = (losses_reg  == '1) ? losses_reg  : losses_reg  + LOSS_W'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CW'(1);
        retries_next = retries_reg;
        losses_next  = losses_reg;

        case (state_reg)
            ST_ASSERT: begin
                if (cnt_reg == RST_LAST) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (lk && !stp) begin
                    state_next = ST_SETTLE;
                end else if (cnt_reg == LOCK_LAST) begin
                    retries_next = retry_inc;
                    state_next   = (retry_inc > RETRY_MAX) ? ST_FAULT : ST_ASSERT;
                end
            end
            ST_SETTLE: begin
                if (lost) begin
                    state_next = ST_WAIT;
                end else if (cnt_reg == SETTLE_LAST) begin
                    state_next   = ST_RUN;
                    retries_next = '0;
                end
            end
            ST_RUN: begin
                // cnt tracks the current run of lost cycles only
                if (!lost) begin
                    cnt_next = '0;
                end else if (cnt_reg == LOSS_LAST) begin
                    losses_next = loss_inc;
                    state_next  = ST_ASSERT;
                end
            end
            ST_FAULT: begin
                cnt_next = cnt_reg;
            end
            default: begin
                state_next = ST_ASSERT;
            end
        endcase

        if (state_next != state_reg) cnt_next = '0;

        if (restart) begin
            state_next   = ST_ASSERT;
            cnt_next     = '0;
            retries_next = '0;
            losses_next  = losses_reg;
        end
    end

    // Outputs are decoded from the next state so they line up with state entry.
    always_comb begin
        dcm_rst_next = (state_next == ST_ASSERT) || (state_next == ST_FAULT);
        ready_next   = (state_next == ST_RUN);
        fault_next   = (state_next == ST_FAULT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_ASSERT;
            cnt_reg     <= '0;
            retries_reg <= '0;
            losses_reg  <= '0;
            dcm_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            sys_rst_reg <= 1'b1;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retries_reg <= retries_next;
            losses_reg  <= losses_next;
            dcm_rst_reg <= dcm_rst_next;
            ready_reg   <= ready_next;
            sys_rst_reg <= !ready_next;
            fault_reg   <= fault_next;
        end
    end

    assign dcm_rst = dcm_rst_reg;
    assign ready   = ready_reg;
    assign sys_rst = sys_rst_reg;
    assign fault   = fault_reg;
    assign retries = retries_reg;
    assign losses  = losses_reg;

endmodule

// File: doc/clock_sequencer.md
Name: clock_sequencer

Overview:
- Supervises the DCM-based clock generator that turns the 50 MHz board clock into the 200 MHz SDRAM/system clock.
- Pulses the DCM reset, waits for a stable lock, and only then releases the downstream system reset.
- Detects lock loss or input-clock stop, retries a bounded number of times, then reports a fault.
- Runs on the free-running 50 MHz input clock, which is valid before the DCM locks.

Parameters:
- RST_CYCLES, 8: DCM reset pulse width in clock cycles; must be ≥3 (DCM_SP minimum).
- LOCK_TIMEOUT, 50000: cycles to wait for lock before retrying (1 ms at 50 MHz).
- SETTLE_CYCLES, 1024: consecutive synchronized-locked cycles required before ready.
- LOSS_FILTER, 4: consecutive unlocked cycles in RUN that count as a real loss.
- MAX_RETRY, 7: failed lock attempts tolerated before FAULT.
- CW, 16: shared counter width; must hold the largest of the three cycle parameters.

Ports:
- clock, in, 1: 50 MHz board clock, pre-DCM.
- reset, in, 1: asynchronous, active-low.
- locked, in, 1: DCM LOCKED; asynchronous to clock, synchronized internally.
- clkin_stopped, in, 1: DCM STATUS[1]; asynchronous, synchronized internally.
- restart, in, 1: synchronous pulse; forces a full re-lock and leaves FAULT.
- dcm_rst, out, 1: drives DCM RST, active high.
- ready, out, 1: clocks stable.
- sys_rst, out, 1: active-high reset for downstream logic; equals !ready, registered. Consumers in the 200 MHz domain resynchronize it.
- fault, out, 1: retry budget exhausted.
- retries, out, 4: failed lock attempts since the last success, saturating.
- losses, out, 8: lock-loss events in RUN since reset, saturating at 255.

Behaviour:
- Reset state: asynchronous on reset low, when all outputs take their reset values.
  - State ASSERT, counters 0.
  - dcm_rst=1, ready=0, sys_rst=1, fault=0, retries=0, losses=0.
- Synchronizers: locked and clkin_stopped each pass through 2 flops; the FSM sees lk and stp 2 cycles late. "Lost" means !lk or stp.
- Single counter cnt (CW bits): cleared on every state change; increments otherwise.
- ASSERT: dcm_rst=1.
  - After cnt reaches RST_CYCLES-1, go to WAIT. The pulse is exactly RST_CYCLES cycles.
- WAIT: dcm_rst=0.
  - If lk and !stp, go to SETTLE.
  - Else if cnt reaches LOCK_TIMEOUT-1: retries += 1 (saturating). If the incremented value is greater than MAX_RETRY, go to FAULT; otherwise go to ASSERT.
- SETTLE: if lost, go to WAIT; the timeout restarts and retries is unchanged. If cnt reaches SETTLE_CYCLES-1, go to RUN and clear retries.
- RUN: ready=1 and sys_rst=0, both registered and asserted in the first RUN cycle.
  - cnt counts consecutive lost cycles and clears while not lost.
  - When cnt reaches LOSS_FILTER-1 while lost: losses += 1 (saturating), go to ASSERT. ready falls in the same cycle dcm_rst rises.
  - Glitches shorter than LOSS_FILTER cycles are ignored.
- FAULT: dcm_rst=1 (DCM held in reset), fault=1, ready=0. Only restart or reset leaves FAULT.
- restart: from any state, go to ASSERT next cycle with cnt=0, fault=0, retries=0. losses is kept.
  - restart takes priority over every other transition in that cycle.
- ready and sys_rst are always complements, and both change only on state entry or exit.
- Entry to RUN leaves retries=0.
- An unused state encoding goes to ASSERT.

Decomposition:
- Shared package clock_pkg holds:
  - the state enumeration (ASSERT, WAIT, SETTLE, RUN, FAULT; 3-bit);
  - the retry and loss counter widths (4, 8).
- One sub-module: sync2, a generic 2-flop synchronizer with asynchronous active-low reset to 0. It is instantiated for locked and clkin_stopped and is reusable elsewhere in the codebase.
- The FSM, counters and output registers stay in clock_sequencer.

Test Plan (bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=16, LOSS_FILTER=3, MAX_RETRY=2):
- Nominal lock: release reset, drive locked=1 from cycle 20 -> dcm_rst high for exactly 4 cycles; ready rises 2+1+16 cycles after locked rises; sys_rst=!ready; retries=0.
- Loss filter: in RUN, drop locked for 2 cycles -> ready stays 1 and losses=0. Drop it for 3 cycles -> ready falls, dcm_rst pulses 4 cycles, losses=1; the block re-locks when locked returns.
- Timeout and fault: hold locked=0 -> three dcm_rst pulses, each ending 100 cycles before the next timeout. After the 3rd timeout, retries=3, fault=1 and dcm_rst is held high. Pulse restart -> fault=0, retries=0, ASSERT.
- Settle abort: lock, drop locked at cycle 10 of SETTLE -> back to WAIT with no dcm_rst pulse; ready never asserts; re-lock succeeds with retries=0.
- Clock stop: in RUN, assert clkin_stopped with locked=1 for 3 cycles -> ready=0, losses increments, dcm_rst pulses.
- Async reset mid-RUN: pull reset low for a partial cycle -> all outputs return to their reset values immediately; losses=0; the sequence restarts from ASSERT.
